// File: rtl/param_sync_fifo_if.sv
// rtl/param_sync_fifo_if.sv - write/read/status bundle of the parametrised sync FIFO
interface param_sync_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                   flush;
    logic                   wr_en;
    logic [WIDTH-1:0]       wr_data;
    logic                   rd_en;
    logic [WIDTH-1:0]       rd_data;
    logic                   rd_valid;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   underflow;
    logic                   err_clr;

    modport master (
        output flush, wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with count, threshold flags,
// sticky error flags, flush and selectable first-word-fall-through read
module param_sync_fifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0
) (
    input logic              clk,
    input logic              rst,
    param_sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

    generate
        if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
            AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
            AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1 ||
            (FWFT != 0 && FWFT != 1)) begin : g_bad_params
            $error("param_sync_fifo: illegal parameter set");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    countQ;
    logic [AW-1:0]    wrIdx;
    logic [AW-1:0]    rdIdx;
    logic             isFull;
    logic             isEmpty;
    logic             wrAccept;
    logic             rdAccept;
    logic             overflowQ;
    logic             underflowQ;

    assign wrIdx = wrPtr[AW-1:0];
    assign rdIdx = rdPtr[AW-1:0];

    // Flags decode the registered count, so they follow the causing edge by one cycle.
    assign isFull  = (countQ == DEPTH_C);
    assign isEmpty = (countQ == '0);

    assign wrAccept = bus.wr_en && !isFull;
    assign rdAccept = bus.rd_en && !isEmpty;

    assign bus.full         = isFull;
    assign bus.empty        = isEmpty;
    assign bus.almost_full  = (countQ >= AFULL_C);
    assign bus.almost_empty = (countQ <= AEMPTY_C);
    assign bus.count        = countQ;
    assign bus.overflow     = overflowQ;
    assign bus.underflow    = underflowQ;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            countQ <= '0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (rdAccept) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({wrAccept, rdAccept})
                2'b10:   countQ <= countQ + PW'(1);
                2'b01:   countQ <= countQ - PW'(1);
                default: countQ <= countQ;
            endcase
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && wrAccept) begin
            mem[wrIdx] <= bus.wr_data;
        end
    end

    // A new error in the same cycle as err_clr wins, so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            overflowQ  <= (overflowQ && !bus.err_clr) ||
                          (bus.wr_en && isFull && !bus.flush);
            underflowQ <= (underflowQ && !bus.err_clr) ||
                          (bus.rd_en && isEmpty && !bus.flush);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rd_data  = mem[rdIdx];
            assign bus.rd_valid = !isEmpty;
        end else begin : g_registered
            logic [WIDTH-1:0] rdDataQ;
            logic             rdValidQ;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdDataQ  <= '0;
                    rdValidQ <= 1'b0;
                end else if (bus.flush) begin
                    rdValidQ <= 1'b0;
                end else begin
                    rdValidQ <= rdAccept;
                    if (rdAccept) begin
                        rdDataQ <= mem[rdIdx];
                    end
                end
            end

            assign bus.rd_data  = rdDataQ;
            assign bus.rd_valid = rdValidQ;
        end
    endgenerate
endmodule
